// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
//   Shared constants and bus layouts for the instruction-fetch stage.
//   - BR_BUS_WD        : width of the decode-to-fetch branch bus
//   - FS_TO_DS_BUS_WD  : width of the fetch-to-decode bus
//   - RESET_PC_DEFAULT : address of the first fetch after reset
//   - br_bus_t         : {taken, target} view of the branch bus
//   - fs_to_ds_t       : {inst, pc} view of the fetch-to-decode bus
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int BR_BUS_WD       = 33;
    localparam int FS_TO_DS_BUS_WD = 64;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    // Fixed attributes of every instruction-side transfer (word reads only).
    localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;
    localparam logic [3:0]  SRAM_WSTRB_RD  = 4'b0000;
    localparam logic [31:0] SRAM_WDATA_RD  = 32'h0000_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    // Sequential successor of a PC; wraps naturally at 32 bits.
    function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch front end. Computes the next PC, issues word reads on
//   an SRAM-like req/addr_ok/data_ok interface (at most one outstanding),
//   holds the returned instruction until decode takes it, and squashes
//   wrong-path fetches when decode reports a taken branch.
//
// Ports
//   clk, reset             : clock; asynchronous active-high reset
//   ds_allowin             : decode can accept an instruction this cycle
//   br_bus                 : {br_taken, br_target} from decode
//   fs_to_ds_valid/bus     : {inst, pc} handed to decode
//   inst_sram_req/addr     : read request and its address (== nextpc)
//   inst_sram_wr/size/wstrb/wdata : constant read attributes
//   inst_sram_addr_ok      : request accepted this cycle
//   inst_sram_data_ok/rdata: read data returned this cycle
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,

    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic        fs_valid_reg,      fs_valid_next;
    logic [31:0] fs_pc_reg,         fs_pc_next;
    logic        outstanding_reg,   outstanding_next;
    logic        drop_pending_reg,  drop_pending_next;
    logic        br_buf_valid_reg,  br_buf_valid_next;
    logic [31:0] br_buf_target_reg, br_buf_target_next;
    logic        inst_buf_valid_reg, inst_buf_valid_next;
    logic [31:0] inst_buf_reg,      inst_buf_next;

    // -------------------------------------------------------------------------
    // Combinational datapath / handshake
    // -------------------------------------------------------------------------
    br_bus_t     br;
    fs_to_ds_t   fs_out;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] nextpc;
    logic        data_ok_eff;
    logic        fs_ready_go;
    logic [31:0] fs_inst;
    logic        fs_valid_out;
    logic        fs_leaving;
    logic        fs_cancel_done;
    logic        req;
    logic        accept;

    assign br        = br_bus;
    assign br_taken  = br.taken;
    assign br_target = br.target;

    always_comb begin
        // A pending redirect that has not been issued yet beats everything.
        if (br_buf_valid_reg) begin
            nextpc = br_buf_target_reg;
        end else if (br_taken) begin
            nextpc = br_target;
        end else begin
            nextpc = seq_next_pc(fs_pc_reg);
        end
    end

    // data_ok only has meaning while a request is in flight.
    assign data_ok_eff  = outstanding_reg && inst_sram_data_ok;

    // Returned data belongs to the IF instruction unless it is the one
    // response we owe to a squashed fetch.
    assign fs_ready_go  = inst_buf_valid_reg || (data_ok_eff && !drop_pending_reg);
    assign fs_inst      = inst_buf_valid_reg ? inst_buf_reg : inst_sram_rdata;

    assign fs_valid_out = fs_valid_reg && fs_ready_go && !br_taken;
    assign fs_leaving   = fs_valid_out && ds_allowin;

    // A squashed IF instruction whose data is already here (or arriving now)
    // frees the slot immediately, so the branch target can be requested in
    // the same cycle instead of waiting for a drop.
    assign fs_cancel_done = fs_valid_reg && br_taken &&
                            (inst_buf_valid_reg || data_ok_eff);

    // Gated by reset as well so the request falls the moment reset rises,
    // not at the next edge.
    assign req    = !reset && !drop_pending_reg &&
                    (!fs_valid_reg || fs_leaving || fs_cancel_done);
    assign accept = req && inst_sram_addr_ok;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fs_valid_next       = fs_valid_reg;
        fs_pc_next          = fs_pc_reg;
        outstanding_next    = outstanding_reg;
        drop_pending_next   = drop_pending_reg;
        br_buf_valid_next   = br_buf_valid_reg;
        br_buf_target_next  = br_buf_target_reg;
        inst_buf_valid_next = inst_buf_valid_reg;
        inst_buf_next       = inst_buf_reg;

        // IF slot: a new accept always wins; otherwise the slot empties when
        // its instruction leaves or is squashed.
        if (accept) begin
            fs_valid_next = 1'b1;
            fs_pc_next    = nextpc;
        end else if (fs_leaving || br_taken) begin
            fs_valid_next = 1'b0;
        end

        // In-flight tracking. Accept and data_ok together hand the slot
        // straight over to the new request.
        if (accept) begin
            outstanding_next = 1'b1;
        end else if (data_ok_eff) begin
            outstanding_next = 1'b0;
        end

        // Squash with data still owed: swallow exactly one later data_ok.
        if (data_ok_eff && drop_pending_reg) begin
            drop_pending_next = 1'b0;
        end else if (br_taken && outstanding_reg && !inst_sram_data_ok) begin
            drop_pending_next = 1'b1;
        end

        // Instruction buffer: park data decode cannot take this cycle.
        if (data_ok_eff && !drop_pending_reg && !fs_leaving && !br_taken) begin
            inst_buf_valid_next = 1'b1;
            inst_buf_next       = inst_sram_rdata;
        end else if (fs_leaving || br_taken) begin
            inst_buf_valid_next = 1'b0;
        end

        // Branch buffer: remember a redirect the memory did not take yet.
        // Decode guarantees no second taken branch while one is buffered,
        // so an existing entry is never replaced.
        if (accept) begin
            br_buf_valid_next = 1'b0;
        end else if (br_taken && !br_buf_valid_reg) begin
            br_buf_valid_next  = 1'b1;
            br_buf_target_next = br_target;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid_reg       <= 1'b0;
            // One word before the first fetch so the sequential path
            // produces RESET_PC as the first request address.
            fs_pc_reg          <= RESET_PC - INST_BYTES;
            outstanding_reg    <= 1'b0;
            drop_pending_reg   <= 1'b0;
            br_buf_valid_reg   <= 1'b0;
            br_buf_target_reg  <= 32'h0;
            inst_buf_valid_reg <= 1'b0;
            inst_buf_reg       <= 32'h0;
        end else begin
            fs_valid_reg       <= fs_valid_next;
            fs_pc_reg          <= fs_pc_next;
            outstanding_reg    <= outstanding_next;
            drop_pending_reg   <= drop_pending_next;
            br_buf_valid_reg   <= br_buf_valid_next;
            br_buf_target_reg  <= br_buf_target_next;
            inst_buf_valid_reg <= inst_buf_valid_next;
            inst_buf_reg       <= inst_buf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fs_out.inst     = fs_inst;
    assign fs_out.pc       = fs_pc_reg;
    assign fs_to_ds_bus    = fs_out;
    assign fs_to_ds_valid  = fs_valid_out;

    assign inst_sram_req   = req;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SRAM_SIZE_WORD;
    assign inst_sram_wstrb = SRAM_WSTRB_RD;
    assign inst_sram_wdata = SRAM_WDATA_RD;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. A small memory responder and a
//   program-order PC model (expected next delivered PC, redirected by taken
//   branches) run inside the cycle driver; each test task checks its own
//   observations.
// -----------------------------------------------------------------------------
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] BR_PC  = 32'h1c00_0100;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       ds_allowin = 1'b0;
    logic [BR_BUS_WD-1:0]       br_bus = '0;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_req;
    logic                       inst_sram_wr;
    logic [1:0]                 inst_sram_size;
    logic [3:0]                 inst_sram_wstrb;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic                       inst_sram_addr_ok = 1'b0;
    logic                       inst_sram_data_ok = 1'b0;
    logic [31:0]                inst_sram_rdata = 32'h0;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Memory responder state
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_due  = 0;
    int          cyc      = 0;
    logic        ovr_en   = 1'b0;
    logic [31:0] ovr_inst = 32'h0;

    // Program-order model: PC of the next instruction decode should receive.
    logic [31:0] exp_pc = RST_PC;

    // Per-cycle observations
    logic        obs_req, obs_valid, obs_deliver, obs_accept, obs_dok, obs_overlap;
    logic [31:0] obs_addr, obs_pc, obs_inst, obs_exp_pc, obs_exp_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (ovr_en) return ovr_inst;
        return {a[15:0], a[31:16]} ^ 32'h3c5a_96e1;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic allow, input logic br, input logic [31:0] tgt,
                        input logic aok, input int lat);
        logic busy_before;
        ds_allowin        = allow;
        br_bus            = {br, tgt};
        inst_sram_addr_ok = aok;
        if (mem_busy && mem_due == cyc) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(mem_addr);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        #1;
        obs_req      = inst_sram_req;
        obs_addr     = inst_sram_addr;
        obs_valid    = fs_to_ds_valid;
        obs_pc       = fs_to_ds_bus[31:0];
        obs_inst     = fs_to_ds_bus[63:32];
        obs_dok      = inst_sram_data_ok;
        obs_deliver  = obs_valid && allow;
        obs_accept   = obs_req && aok;
        obs_exp_pc   = exp_pc;
        obs_exp_inst = inst_of(exp_pc);
        busy_before  = mem_busy;
        obs_overlap  = obs_accept && busy_before && !obs_dok;
        if (obs_dok) mem_busy = 1'b0;
        if (obs_accept) begin
            mem_busy = 1'b1;
            mem_addr = obs_addr;
            mem_due  = cyc + lat;
        end
        if (br) exp_pc = tgt;
        else if (obs_deliver) exp_pc = exp_pc + 32'd4;
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        mem_busy = 1'b0;
        exp_pc   = RST_PC;
        ovr_en   = 1'b0;
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        ds_allowin        = 1'b0;
        br_bus            = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset             = 1'b1;
        inst_sram_addr_ok = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (inst_sram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", inst_sram_req);
        else passed++;
        checks++;
        if (fs_to_ds_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC)
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", obs_req, obs_addr, RST_PC);
        else passed++;
        $display("test_reset: first addr %h", obs_addr);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1);
            checks++;
            if (obs_deliver !== 1'b1 || obs_pc !== RST_PC + 32'(4 * i) || obs_inst !== obs_exp_inst)
                $display("FAIL stream_%0d: got valid=%b pc=%h inst=%h want valid=1 pc=%h inst=%h",
                         i, obs_deliver, obs_pc, obs_inst, RST_PC + 32'(4 * i), obs_exp_inst);
            else passed++;
            $display("test_stream: delivered pc %h", obs_pc);
        end
    endtask

    task automatic test_stall();
        logic [63:0] held;
        ovr_en   = 1'b1;
        ovr_inst = 32'h0280_0421;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1);
        held = {obs_inst, obs_pc};
        checks++;
        if (obs_dok !== 1'b1 || obs_valid !== 1'b1 || obs_req !== 1'b0 ||
            obs_inst !== 32'h0280_0421 || obs_pc !== obs_exp_pc)
            $display("FAIL stall_arrive: got dok=%b valid=%b req=%b inst=%h pc=%h want 1 1 0 02800421 %h",
                     obs_dok, obs_valid, obs_req, obs_inst, obs_pc, obs_exp_pc);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1);
            checks++;
            if (obs_valid !== 1'b1 || obs_req !== 1'b0 || {obs_inst, obs_pc} !== held)
                $display("FAIL stall_hold_%0d: got valid=%b req=%b bus=%h want 1 0 %h",
                         i, obs_valid, obs_req, {obs_inst, obs_pc}, held);
            else passed++;
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || {obs_inst, obs_pc} !== held ||
            obs_req !== 1'b1 || obs_addr !== held[31:0] + 32'd4)
            $display("FAIL stall_release: got valid=%b bus=%h req=%b addr=%h want 1 %h 1 %h",
                     obs_deliver, {obs_inst, obs_pc}, obs_req, obs_addr, held, held[31:0] + 32'd4);
        else passed++;
        ovr_en = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || obs_pc !== held[31:0] + 32'd4 || obs_inst !== obs_exp_inst)
            $display("FAIL stall_resume: got valid=%b pc=%h inst=%h want 1 %h %h",
                     obs_deliver, obs_pc, obs_inst, held[31:0] + 32'd4, obs_exp_inst);
        else passed++;
        $display("test_stall: held pc %h resumed at %h", held[31:0], obs_pc);
    endtask

    task automatic test_branch_returned();
        apply_reset();
        stream(3);
        step(1'b1, 1'b1, BR_PC, 1'b1, 1);
        checks++;
        if (obs_valid !== 1'b0 || obs_dok !== 1'b1)
            $display("FAIL br_ret_squash: got valid=%b dok=%b want 0 1", obs_valid, obs_dok);
        else passed++;
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== BR_PC)
            $display("FAIL br_ret_req: got req=%b addr=%h want 1 %h", obs_req, obs_addr, BR_PC);
        else passed++;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || obs_pc !== BR_PC || obs_inst !== inst_of(BR_PC))
            $display("FAIL br_ret_next: got valid=%b pc=%h inst=%h want 1 %h %h",
                     obs_deliver, obs_pc, obs_inst, BR_PC, inst_of(BR_PC));
        else passed++;
        $display("test_branch_returned: next pc %h", obs_pc);
    endtask

    task automatic test_branch_outstanding();
        logic found;
        logic saw_dok;
        apply_reset();
        stream(2);
        step(1'b1, 1'b0, 32'h0, 1'b1, 3);
        step(1'b1, 1'b1, BR_PC, 1'b1, 1);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b0)
            $display("FAIL br_out_squash: got valid=%b req=%b want 0 0", obs_valid, obs_req);
        else passed++;
        found   = 1'b0;
        saw_dok = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1);
            if (obs_req) begin
                found = 1'b1;
            end else begin
                if (obs_dok) saw_dok = 1'b1;
                checks++;
                if (obs_valid !== 1'b0)
                    $display("FAIL br_out_stale: got valid=%b pc=%h want 0", obs_valid, obs_pc);
                else passed++;
            end
        end
        checks++;
        if (!found || !saw_dok || obs_addr !== BR_PC)
            $display("FAIL br_out_req: got found=%b dropped=%b addr=%h want 1 1 %h",
                     found, saw_dok, obs_addr, BR_PC);
        else passed++;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || obs_pc !== BR_PC || obs_inst !== inst_of(BR_PC))
            $display("FAIL br_out_next: got valid=%b pc=%h inst=%h want 1 %h %h",
                     obs_deliver, obs_pc, obs_inst, BR_PC, inst_of(BR_PC));
        else passed++;
        $display("test_branch_outstanding: next pc %h", obs_pc);
    endtask

    task automatic test_branch_addr_stall();
        apply_reset();
        stream(3);
        step(1'b1, 1'b1, BR_PC, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== BR_PC)
                $display("FAIL br_aok_hold_%0d: got req=%b addr=%h want 1 %h", i, obs_req, obs_addr, BR_PC);
            else passed++;
            if (i < 3) step(1'b1, 1'b0, 32'h0, 1'b0, 1);
        end
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_accept !== 1'b1 || obs_addr !== BR_PC)
            $display("FAIL br_aok_accept: got accept=%b addr=%h want 1 %h", obs_accept, obs_addr, BR_PC);
        else passed++;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || obs_pc !== BR_PC)
            $display("FAIL br_aok_next: got valid=%b pc=%h want 1 %h", obs_deliver, obs_pc, BR_PC);
        else passed++;
        $display("test_branch_addr_stall: next pc %h", obs_pc);
    endtask

    task automatic test_async_reset();
        apply_reset();
        stream(3);
        #1;
        checks++;
        if (fs_to_ds_valid !== 1'b1 || inst_sram_req !== 1'b1)
            $display("FAIL areset_pre: got valid=%b req=%b want 1 1", fs_to_ds_valid, inst_sram_req);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b0)
            $display("FAIL areset_fall: got valid=%b req=%b want 0 0", fs_to_ds_valid, inst_sram_req);
        else passed++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC)
            $display("FAIL areset_restart: got req=%b addr=%h want 1 %h", obs_req, obs_addr, RST_PC);
        else passed++;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1);
        checks++;
        if (obs_deliver !== 1'b1 || obs_pc !== RST_PC)
            $display("FAIL areset_first: got valid=%b pc=%h want 1 %h", obs_deliver, obs_pc, RST_PC);
        else passed++;
        $display("test_async_reset: restarted at %h", obs_pc);
    endtask

    task automatic test_random();
        logic        br_ok;
        logic        prev_valid, prev_allow;
        logic [63:0] prev_bus;
        logic        allow, aok, br;
        logic [31:0] tgt;
        int          lat;
        int          delivered;
        apply_reset();
        br_ok      = 1'b1;
        prev_valid = 1'b0;
        prev_allow = 1'b1;
        prev_bus   = '0;
        delivered  = 0;
        for (int n = 0; n < 4000; n++) begin
            allow = ($urandom % 10) < 7;
            aok   = ($urandom % 4) != 0;
            lat   = 1 + int'($urandom % 3);
            br    = br_ok && (($urandom % 8) == 0);
            case ($urandom % 4)
                0:       tgt = 32'hffff_fff8;
                1:       tgt = BR_PC;
                default: tgt = {$urandom, 2'b00} & 32'hffff_fffc;
            endcase
            step(allow, br, tgt, aok, lat);
            if (br) begin
                checks++;
                if (obs_valid !== 1'b0)
                    $display("FAIL rnd_squash@%0d: got valid=%b want 0", cyc, obs_valid);
                else passed++;
            end
            if (prev_valid && !prev_allow && !br) begin
                checks++;
                if (obs_valid !== 1'b1 || {obs_inst, obs_pc} !== prev_bus)
                    $display("FAIL rnd_hold@%0d: got valid=%b bus=%h want 1 %h",
                             cyc, obs_valid, {obs_inst, obs_pc}, prev_bus);
                else passed++;
            end
            if (obs_accept) begin
                checks++;
                if (obs_overlap)
                    $display("FAIL rnd_overlap@%0d: got second outstanding req addr=%h want none", cyc, obs_addr);
                else passed++;
            end
            if (obs_deliver) begin
                delivered++;
                br_ok = 1'b1;
                checks++;
                if (obs_pc !== obs_exp_pc || obs_inst !== obs_exp_inst)
                    $display("FAIL rnd_deliver@%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             cyc, obs_pc, obs_inst, obs_exp_pc, obs_exp_inst);
                else passed++;
            end
            if (br) br_ok = 1'b0;
            prev_valid = obs_valid;
            prev_allow = allow;
            prev_bus   = {obs_inst, obs_pc};
        end
        checks++;
        if (delivered < 500)
            $display("FAIL rnd_progress: got %0d deliveries want >= 500", delivered);
        else passed++;
        $display("test_random: %0d instructions delivered", delivered);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_returned();
        test_branch_outstanding();
        test_branch_addr_stall();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
